des_decrypt_core: RTL and testbench



---
 rtl/des_pkg.sv | 158 +++++++++++++++
 rtl/des_f_function.sv | 27 ++
 rtl/des_sbox_luts.sv | 56 +++++
 rtl/des_decrypt_core.sv | 156 +++++++++++++++
 tb/tb_des_decrypt_core.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/des_pkg.sv
// Shared DES constants: bit-permutation tables (DES 1-based numbering,
// bit 1 = MSB), S-box contents, decrypt rotate schedule, widths, FSM states
// and the permutation helpers used by both the decrypt and encrypt datapaths.
package des_pkg;

    localparam int BLK    = 64;
    localparam int HALF   = 32;
    localparam int KHALF  = 28;
    localparam int SUBKEY = 48;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ROUND = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Round counter: 1..16 are Feistel rounds, 17 is the output-capture step
    localparam logic [4:0] RND_ZERO  = 5'd0;
    localparam logic [4:0] RND_FIRST = 5'd1;
    localparam logic [4:0] RND_FINAL = 5'd17;

    // Right-rotate amount for decrypt rounds 1..16 (indexed by round-1).
    // Round 1 uses C16/D16 == C0/D0, so no rotation before K16.
    localparam logic [1:0] RSH_DEC [16] = '{
        2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};

    localparam logic [6:0] IP_TBL [64] = '{
        7'd58, 7'd50, 7'd42, 7'd34, 7'd26, 7'd18, 7'd10, 7'd2,
        7'd60, 7'd52, 7'd44, 7'd36, 7'd28, 7'd20, 7'd12, 7'd4,
        7'd62, 7'd54, 7'd46, 7'd38, 7'd30, 7'd22, 7'd14, 7'd6,
        7'd64, 7'd56, 7'd48, 7'd40, 7'd32, 7'd24, 7'd16, 7'd8,
        7'd57, 7'd49, 7'd41, 7'd33, 7'd25, 7'd17, 7'd9,  7'd1,
        7'd59, 7'd51, 7'd43, 7'd35, 7'd27, 7'd19, 7'd11, 7'd3,
        7'd61, 7'd53, 7'd45, 7'd37, 7'd29, 7'd21, 7'd13, 7'd5,
        7'd63, 7'd55, 7'd47, 7'd39, 7'd31, 7'd23, 7'd15, 7'd7};

    localparam logic [6:0] FP_TBL [64] = '{
        7'd40, 7'd8, 7'd48, 7'd16, 7'd56, 7'd24, 7'd64, 7'd32,
        7'd39, 7'd7, 7'd47, 7'd15, 7'd55, 7'd23, 7'd63, 7'd31,
        7'd38, 7'd6, 7'd46, 7'd14, 7'd54, 7'd22, 7'd62, 7'd30,
        7'd37, 7'd5, 7'd45, 7'd13, 7'd53, 7'd21, 7'd61, 7'd29,
        7'd36, 7'd4, 7'd44, 7'd12, 7'd52, 7'd20, 7'd60, 7'd28,
        7'd35, 7'd3, 7'd43, 7'd11, 7'd51, 7'd19, 7'd59, 7'd27,
        7'd34, 7'd2, 7'd42, 7'd10, 7'd50, 7'd18, 7'd58, 7'd26,
        7'd33, 7'd1, 7'd41, 7'd9,  7'd49, 7'd17, 7'd57, 7'd25};

    localparam logic [6:0] E_TBL [48] = '{
        7'd32, 7'd1,  7'd2,  7'd3,  7'd4,  7'd5,
        7'd4,  7'd5,  7'd6,  7'd7,  7'd8,  7'd9,
        7'd8,  7'd9,  7'd10, 7'd11, 7'd12, 7'd13,
        7'd12, 7'd13, 7'd14, 7'd15, 7'd16, 7'd17,
        7'd16, 7'd17, 7'd18, 7'd19, 7'd20, 7'd21,
        7'd20, 7'd21, 7'd22, 7'd23, 7'd24, 7'd25,
        7'd24, 7'd25, 7'd26, 7'd27, 7'd28, 7'd29,
        7'd28, 7'd29, 7'd30, 7'd31, 7'd32, 7'd1};

    localparam logic [6:0] P_TBL [32] = '{
        7'd16, 7'd7,  7'd20, 7'd21, 7'd29, 7'd12, 7'd28, 7'd17,
        7'd1,  7'd15, 7'd23, 7'd26, 7'd5,  7'd18, 7'd31, 7'd10,
        7'd2,  7'd8,  7'd24, 7'd14, 7'd32, 7'd27, 7'd3,  7'd9,
        7'd19, 7'd13, 7'd30, 7'd6,  7'd22, 7'd11, 7'd4,  7'd25};

    // PC1 never references bits 8,16..64, so key parity has no effect
    localparam logic [6:0] PC1_TBL [56] = '{
        7'd57, 7'd49, 7'd41, 7'd33, 7'd25, 7'd17, 7'd9,
        7'd1,  7'd58, 7'd50, 7'd42, 7'd34, 7'd26, 7'd18,
        7'd10, 7'd2,  7'd59, 7'd51, 7'd43, 7'd35, 7'd27,
        7'd19, 7'd11, 7'd3,  7'd60, 7'd52, 7'd44, 7'd36,
        7'd63, 7'd55, 7'd47, 7'd39, 7'd31, 7'd23, 7'd15,
        7'd7,  7'd62, 7'd54, 7'd46, 7'd38, 7'd30, 7'd22,
        7'd14, 7'd6,  7'd61, 7'd53, 7'd45, 7'd37, 7'd29,
        7'd21, 7'd13, 7'd5,  7'd28, 7'd20, 7'd12, 7'd4};

    localparam logic [6:0] PC2_TBL [48] = '{
        7'd14, 7'd17, 7'd11, 7'd24, 7'd1,  7'd5,
        7'd3,  7'd28, 7'd15, 7'd6,  7'd21, 7'd10,
        7'd23, 7'd19, 7'd12, 7'd4,  7'd26, 7'd8,
        7'd16, 7'd7,  7'd27, 7'd20, 7'd13, 7'd2,
        7'd41, 7'd52, 7'd31, 7'd37, 7'd47, 7'd55,
        7'd30, 7'd40, 7'd51, 7'd45, 7'd33, 7'd48,
        7'd44, 7'd49, 7'd39, 7'd56, 7'd34, 7'd53,
        7'd46, 7'd42, 7'd50, 7'd36, 7'd29, 7'd32};

    // S-boxes: one hex digit per entry, entry (row*16+col) at digit position
    // from the left, rows 0..3 separated by underscores.
    localparam logic [255:0] S1_TBL = 256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D;
    localparam logic [255:0] S2_TBL = 256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9;
    localparam logic [255:0] S3_TBL = 256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C;
    localparam logic [255:0] S4_TBL = 256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E;
    localparam logic [255:0] S5_TBL = 256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453;
    localparam logic [255:0] S6_TBL = 256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D;
    localparam logic [255:0] S7_TBL = 256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C;
    localparam logic [255:0] S8_TBL = 256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B;

    function automatic logic [63:0] ip_perm(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 64; i++) y[63 - i] = x[64 - int'(IP_TBL[i])];
        return y;
    endfunction

    function automatic logic [63:0] fp_perm(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 64; i++) y[63 - i] = x[64 - int'(FP_TBL[i])];
        return y;
    endfunction

    function automatic logic [47:0] e_expand(input logic [31:0] x);
        logic [47:0] y;
        y = '0;
        for (int i = 0; i < 48; i++) y[47 - i] = x[32 - int'(E_TBL[i])];
        return y;
    endfunction

    function automatic logic [31:0] p_perm(input logic [31:0] x);
        logic [31:0] y;
        y = '0;
        for (int i = 0; i < 32; i++) y[31 - i] = x[32 - int'(P_TBL[i])];
        return y;
    endfunction

    function automatic logic [55:0] pc1_perm(input logic [63:0] x);
        logic [55:0] y;
        y = '0;
        for (int i = 0; i < 56; i++) y[55 - i] = x[64 - int'(PC1_TBL[i])];
        return y;
    endfunction

    function automatic logic [47:0] pc2_perm(input logic [55:0] x);
        logic [47:0] y;
        y = '0;
        for (int i = 0; i < 48; i++) y[47 - i] = x[56 - int'(PC2_TBL[i])];
        return y;
    endfunction

    // Right rotation in DES numbering moves bits away from bit 1 (the MSB)
    function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] amt);
        logic [27:0] y;
        case (amt)
            2'd0:    y = x;
            2'd1:    y = {x[0], x[27:1]};
            2'd2:    y = {x[1:0], x[27:2]};
            default: y = x;
        endcase
        return y;
    endfunction

    // Row = outer bits (1,6), column = inner bits (2..5) of the 6-bit group
    function automatic logic [3:0] sbox_lookup(input logic [255:0] tbl, input logic [5:0] six);
        logic [5:0] idx;
        logic [7:0] msb;
        idx = {six[5], six[0], six[4:1]};
        msb = 8'd255 - {idx, 2'b00};
        return tbl[msb -: 4];
    endfunction

endpackage

// File: rtl/des_f_function.sv
// Combinational DES round function f(R, K): expand, key mix, S-boxes,
// P-permutation. Shared by the encrypt and decrypt datapaths.
module des_f_function
    import des_pkg::*;
(
    input  logic [HALF-1:0]   r_i,
    input  logic [SUBKEY-1:0] subkey_i,
    output logic [HALF-1:0]   f_o
);

    logic [SUBKEY-1:0] mixed_s;
    logic [HALF-1:0]   sbox_out_s;

    assign mixed_s = e_expand(r_i) ^ subkey_i;

    sbox1_lut u_sbox1 (.addr_i(mixed_s[47:42]), .data_o(sbox_out_s[31:28]));
    sbox2_lut u_sbox2 (.addr_i(mixed_s[41:36]), .data_o(sbox_out_s[27:24]));
    sbox3_lut u_sbox3 (.addr_i(mixed_s[35:30]), .data_o(sbox_out_s[23:20]));
    sbox4_lut u_sbox4 (.addr_i(mixed_s[29:24]), .data_o(sbox_out_s[19:16]));
    sbox5_lut u_sbox5 (.addr_i(mixed_s[23:18]), .data_o(sbox_out_s[15:12]));
    sbox6_lut u_sbox6 (.addr_i(mixed_s[17:12]), .data_o(sbox_out_s[11:8]));
    sbox7_lut u_sbox7 (.addr_i(mixed_s[11:6]),  .data_o(sbox_out_s[7:4]));
    sbox8_lut u_sbox8 (.addr_i(mixed_s[5:0]),   .data_o(sbox_out_s[3:0]));

    assign f_o = p_perm(sbox_out_s);

endmodule

// File: rtl/des_sbox_luts.sv
// The eight DES S-box lookup tables, 6-bit address in, 4-bit value out.
module sbox1_lut import des_pkg::*; (
    input  logic [5:0] addr_i,
    output logic [3:0] data_o
);
    assign data_o = sbox_lookup(S1_TBL, addr_i);
endmodule

module sbox2_lut import des_pkg::*; (
    input  logic [5:0] addr_i,
    output logic [3:0] data_o
);
    assign data_o = sbox_lookup(S2_TBL, addr_i);
endmodule

module sbox3_lut import des_pkg::*; (
    input  logic [5:0] addr_i,
    output logic [3:0] data_o
);
    assign data_o = sbox_lookup(S3_TBL, addr_i);
endmodule

module sbox4_lut import des_pkg::*; (
    input  logic [5:0] addr_i,
    output logic [3:0] data_o
);
    assign data_o = sbox_lookup(S4_TBL, addr_i);
endmodule

module sbox5_lut import des_pkg::*; (
    input  logic [5:0] addr_i,
    output logic [3:0] data_o
);
    assign data_o = sbox_lookup(S5_TBL, addr_i);
endmodule

module sbox6_lut import des_pkg::*; (
    input  logic [5:0] addr_i,
    output logic [3:0] data_o
);
    assign data_o = sbox_lookup(S6_TBL, addr_i);
endmodule

module sbox7_lut import des_pkg::*; (
    input  logic [5:0] addr_i,
    output logic [3:0] data_o
);
    assign data_o = sbox_lookup(S7_TBL, addr_i);
endmodule

module sbox8_lut import des_pkg::*; (
    input  logic [5:0] addr_i,
    output logic [3:0] data_o
);
    assign data_o = sbox_lookup(S8_TBL, addr_i);
endmodule

// File: rtl/des_decrypt_core.sv
// Iterative DES decryption: one Feistel round per clock, subkeys K16..K1
// produced on the fly by right-rotating C/D, valid/ready on both sides.
module des_decrypt_core
    import des_pkg::*;
#(
    parameter bit ZEROIZE = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [BLK-1:0] data_in,
    input  logic [BLK-1:0] key_in,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [BLK-1:0] data_out
);

    logic [1:0]        state_q, state_d;
    logic [4:0]        rnd_q, rnd_d;
    logic [HALF-1:0]   l_q, l_d;
    logic [HALF-1:0]   r_q, r_d;
    logic [KHALF-1:0]  c_q, c_d;
    logic [KHALF-1:0]  d_q, d_d;
    logic              out_valid_q, out_valid_d;
    logic [BLK-1:0]    data_out_q, data_out_d;

    logic [BLK-1:0]    ip_s;
    logic [55:0]       pc1_s;
    logic [3:0]        rnd_idx_s;
    logic [1:0]        rsh_s;
    logic [KHALF-1:0]  c_rot_s;
    logic [KHALF-1:0]  d_rot_s;
    logic [SUBKEY-1:0] subkey_s;
    logic [HALF-1:0]   f_s;

    assign ip_s      = ip_perm(data_in);
    assign pc1_s     = pc1_perm(key_in);

    // Rounds 1..16 map to table entries 0..15 (round 16 wraps to 15)
    assign rnd_idx_s = rnd_q[3:0] - 4'd1;
    assign rsh_s     = RSH_DEC[rnd_idx_s];
    assign c_rot_s   = rotr28(c_q, rsh_s);
    assign d_rot_s   = rotr28(d_q, rsh_s);
    assign subkey_s  = pc2_perm({c_rot_s, d_rot_s});

    des_f_function u_f (
        .r_i      (r_q),
        .subkey_i (subkey_s),
        .f_o      (f_s)
    );

    // A new block may be taken while idle, or in the same cycle the held result leaves
    assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    assign out_valid = out_valid_q;
    assign data_out  = data_out_q;

    // Next-state logic: block load, Feistel rounds, output capture and output handshake
    always_comb begin
        state_d     = state_q;
        rnd_d       = rnd_q;
        l_d         = l_q;
        r_d         = r_q;
        c_d         = c_q;
        d_d         = d_q;
        out_valid_d = out_valid_q;
        data_out_d  = data_out_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = ST_ROUND;
                    rnd_d   = RND_FIRST;
                    l_d     = ip_s[BLK-1:HALF];
                    r_d     = ip_s[HALF-1:0];
                    c_d     = pc1_s[55:KHALF];
                    d_d     = pc1_s[KHALF-1:0];
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ROUND: begin
                if (rnd_q == RND_FINAL) begin
                    // {R16,L16} undoes the last-round swap before FP
                    data_out_d  = fp_perm({r_q, l_q});
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                    rnd_d       = RND_ZERO;
                end else begin
                    c_d   = c_rot_s;
                    d_d   = d_rot_s;
                    l_d   = r_q;
                    r_d   = l_q ^ f_s;
                    rnd_d = rnd_q + 5'd1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (in_valid) begin
                        state_d = ST_ROUND;
                        rnd_d   = RND_FIRST;
                        l_d     = ip_s[BLK-1:HALF];
                        r_d     = ip_s[HALF-1:0];
                        c_d     = pc1_s[55:KHALF];
                        d_d     = pc1_s[KHALF-1:0];
                    end else begin
                        state_d = ST_IDLE;
                        rnd_d   = RND_ZERO;
                        if (ZEROIZE) begin
                            l_d = '0;
                            r_d = '0;
                            c_d = '0;
                            d_d = '0;
                        end else begin
                            l_d = l_q;
                            r_d = r_q;
                            c_d = c_q;
                            d_d = d_q;
                        end
                    end
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                rnd_d       = RND_ZERO;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State registers with synchronous reset that also aborts any block in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rnd_q       <= RND_ZERO;
            l_q         <= '0;
            r_q         <= '0;
            c_q         <= '0;
            d_q         <= '0;
            out_valid_q <= 1'b0;
            data_out_q  <= '0;
        end else begin
            state_q     <= state_d;
            rnd_q       <= rnd_d;
            l_q         <= l_d;
            r_q         <= r_d;
            c_q         <= c_d;
            d_q         <= d_d;
            out_valid_q <= out_valid_d;
            data_out_q  <= data_out_d;
        end
    end

endmodule

// File: tb/tb_des_decrypt_core.sv
// Bench for des_decrypt_core: known-answer vectors, handshake corner cases
// and random blocks against a textbook DES reference model.
module tb_des_decrypt_core;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] data_in;
    logic [63:0] key_in;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] data_out;

    int n_checks = 0;
    int n_bad    = 0;

    localparam logic [63:0] K1 = 64'h133457799BBCDFF1;
    localparam logic [63:0] C1 = 64'h85E813540F0AB405;
    localparam logic [63:0] P1 = 64'h0123456789ABCDEF;
    localparam logic [63:0] K2 = 64'h0E329232EA6D0D73;
    localparam logic [63:0] K2F = 64'h0F339333EB6C0C72;
    localparam logic [63:0] C2 = 64'h0000000000000000;
    localparam logic [63:0] P2 = 64'h8787878787878787;

    des_decrypt_core #(.ZEROIZE(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .key_in    (key_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model (textbook DES) ----------------
    int ip_t[$]  = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4, 62,54,46,38,30,22,14,6,
                     64,56,48,40,32,24,16,8, 57,49,41,33,25,17,9,1, 59,51,43,35,27,19,11,3,
                     61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
    int fp_t[$]  = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31, 38,6,46,14,54,22,62,30,
                     37,5,45,13,53,21,61,29, 36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                     34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
    int e_t[$]   = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                     16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
    int p_t[$]   = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                     2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
    int pc1_t[$] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27,
                     19,11,3,60,52,44,36, 63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                     14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
    int pc2_t[$] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                     41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
    int lshift[$] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
    localparam logic [255:0] SB [8] = '{des_pkg::S1_TBL, des_pkg::S2_TBL, des_pkg::S3_TBL,
        des_pkg::S4_TBL, des_pkg::S5_TBL, des_pkg::S6_TBL, des_pkg::S7_TBL, des_pkg::S8_TBL};

    // Output bit i (from the left) takes source bit tbl[i] (from the left); result right-justified
    function automatic logic [63:0] perm(input logic [63:0] src, input int src_w, input int tbl[$]);
        logic [63:0] res;
        int n;
        res = 64'd0;
        n = tbl.size();
        for (int i = 0; i < n; i++) res[n - 1 - i] = src[src_w - tbl[i]];
        return res;
    endfunction

    function automatic logic [31:0] ref_f(input logic [31:0] r, input logic [47:0] k);
        logic [63:0] tmp;
        logic [47:0] x;
        logic [31:0] s;
        logic [5:0]  six;
        logic [5:0]  idx;
        tmp = perm({32'd0, r}, 32, e_t);
        x = tmp[47:0] ^ k;
        s = 32'd0;
        for (int g = 0; g < 8; g++) begin
            six = x[47 - 6*g -: 6];
            idx = {six[5], six[0], six[4:1]};
            s[31 - 4*g -: 4] = SB[g][255 - 4*int'(idx) -: 4];
        end
        tmp = perm({32'd0, s}, 32, p_t);
        return tmp[31:0];
    endfunction

    // Forward key schedule K1..K16, then the Feistel network run with keys reversed
    function automatic logic [63:0] ref_decrypt(input logic [63:0] ct, input logic [63:0] key);
        logic [47:0] ks [1:16];
        logic [63:0] tmp;
        logic [27:0] c, d;
        logic [31:0] l, r, t;
        tmp = perm(key, 64, pc1_t);
        c = tmp[55:28];
        d = tmp[27:0];
        for (int i = 1; i <= 16; i++) begin
            for (int s = 0; s < lshift[i-1]; s++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            tmp = perm({8'd0, c, d}, 56, pc2_t);
            ks[i] = tmp[47:0];
        end
        tmp = perm(ct, 64, ip_t);
        l = tmp[63:32];
        r = tmp[31:0];
        for (int i = 16; i >= 1; i--) begin
            t = r;
            r = l ^ ref_f(r, ks[i]);
            l = t;
        end
        return perm({r, l}, 64, fp_t);
    endfunction

    // ---------------- checking and stimulus helpers ----------------
    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present one block while idle; returns at #1 after the accept edge
    task automatic send(input logic [63:0] ct, input logic [63:0] key);
        check_eq("send_ready", {63'd0, in_ready}, 64'd1);
        in_valid = 1'b1;
        data_in  = ct;
        key_in   = key;
        @(posedge clk); #1;
        in_valid = 1'b0;
        data_in  = {$urandom(), $urandom()};
        key_in   = {$urandom(), $urandom()};
    endtask

    // Wait for out_valid while throwing random in_valid/data at the busy core
    task automatic wait_out(input string tag, input logic [63:0] exp);
        int lat;
        bit seen;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 40) begin
            in_valid = 1'($urandom_range(0, 1));
            data_in  = {$urandom(), $urandom()};
            key_in   = {$urandom(), $urandom()};
            @(posedge clk); #1;
            lat++;
            if (out_valid) begin
                seen = 1'b1;
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b0;
                check_eq({tag, "_busy_ready"}, {63'd0, in_ready}, 64'd0);
            end
        end
        check_eq({tag, "_latency"}, 64'(lat), 64'd17);
        check_eq({tag, "_data"}, data_out, exp);
    endtask

    // Single output handshake with no new block; core must idle and scrub its state
    task automatic take(input logic [63:0] exp);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_eq("hs_valid", {63'd0, out_valid}, 64'd0);
        check_eq("hs_ready", {63'd0, in_ready}, 64'd1);
        check_eq("hs_data_hold", data_out, exp);
        check_eq("zeroize", {63'd0, |{dut.l_q, dut.r_q, dut.c_q, dut.d_q}}, 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] ct, key, exp;
        int rises;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        data_in = 64'd0; key_in = 64'd0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ready", {63'd0, in_ready}, 64'd1);
        check_eq("rst_valid", {63'd0, out_valid}, 64'd0);
        check_eq("rst_data", data_out, 64'd0);
        check_eq("rst_regs", {63'd0, |{dut.l_q, dut.r_q, dut.c_q, dut.d_q}}, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Model sanity against the published vectors
        check_eq("model_fips", ref_decrypt(C1, K1), P1);
        check_eq("model_v2", ref_decrypt(C2, K2), P2);

        // FIPS vector, then 10 cycles of backpressure
        send(C1, K1);
        wait_out("fips", P1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check_eq("bp_valid", {63'd0, out_valid}, 64'd1);
            check_eq("bp_data", data_out, P1);
            check_eq("bp_ready", {63'd0, in_ready}, 64'd0);
        end
        take(P1);

        // Second vector and its parity-flipped key
        send(C2, K2);
        wait_out("v2", P2);
        take(P2);
        send(C2, K2F);
        wait_out("v2_parity", P2);
        take(P2);

        // Back-to-back: second block accepted on the first block's handshake edge
        send(C1, K1);
        wait_out("b2b_a", P1);
        in_valid = 1'b1; data_in = C2; key_in = K2; out_ready = 1'b1;
        #1;
        check_eq("b2b_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        check_eq("b2b_valid_drop", {63'd0, out_valid}, 64'd0);
        check_eq("b2b_busy", {63'd0, in_ready}, 64'd0);
        wait_out("b2b_b", P2);
        take(P2);

        // Reset in round 8 aborts the block
        send(C1, K1);
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq("abort_ready", {63'd0, in_ready}, 64'd1);
        check_eq("abort_valid", {63'd0, out_valid}, 64'd0);
        check_eq("abort_data", data_out, 64'd0);
        rises = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            if (out_valid) rises++;
        end
        check_eq("abort_no_output", 64'(rises), 64'd0);
        send(C2, K2);
        wait_out("after_abort", P2);
        take(P2);

        // Random blocks with random backpressure
        for (int n = 0; n < 16; n++) begin
            ct  = {$urandom(), $urandom()};
            key = {$urandom(), $urandom()};
            exp = ref_decrypt(ct, key);
            send(ct, key);
            wait_out("rand", exp);
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
                check_eq("rand_hold", data_out, exp);
            end
            take(exp);
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
